uart_dec_reader: RTL

UART_DEC_READER -- requirements
Module: uart_dec_reader

---
 rtl/uart_dec_reader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/uart_dec_reader.sv
// ============================================================================
// Module   : uart_dec_reader
// Brief    : Reads a decimal number from UART bytes, echoes digits and CR/LF.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_dec_reader #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             rx_valid,
    input  logic [7:0]       rx_byte,
    input  logic             echo_ready,
    output logic             echo_valid,
    output logic [7:0]       echo_byte,
    output logic             busy,
    output logic             num_valid,
    output logic [WIDTH-1:0] num,
    output logic             overflow
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_READ     = 3'd1;
    localparam logic [2:0] S_ECHO_DIG = 3'd2;
    localparam logic [2:0] S_ECHO_CR  = 3'd3;
    localparam logic [2:0] S_ECHO_LF  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_DIGITS);
    localparam logic [7:0]       c_CR      = 8'h0D;
    localparam logic [7:0]       c_LF      = 8'h0A;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_num;
    logic [7:0]       r_echo_byte;
    logic             r_overflow;
    logic             r_busy;
    logic             r_echo_valid;
    logic             r_num_valid;

    logic [2:0]       w_next_state;
    logic             w_is_digit;
    logic             w_accept_digit;
    logic             w_accept_cr;
    logic [WIDTH+3:0] w_prod;
    logic             w_sat;

    assign w_is_digit     = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
    assign w_accept_digit = (r_state == S_READ) && rx_valid && w_is_digit && (r_cnt < c_MAX_CNT);
    assign w_accept_cr    = (r_state == S_READ) && rx_valid && (rx_byte == c_CR) && (r_cnt != '0);

    // num*10 + digit, four guard bits so saturation is detectable
    assign w_prod = ({4'b0, r_num} << 3) + ({4'b0, r_num} << 1) + (WIDTH+4)'(rx_byte[3:0]);
    assign w_sat  = |w_prod[WIDTH+3:WIDTH];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (start) w_next_state = S_READ;
            S_READ: begin
                if (w_accept_digit)   w_next_state = S_ECHO_DIG;
                else if (w_accept_cr) w_next_state = S_ECHO_CR;
            end
            S_ECHO_DIG: if (echo_ready) w_next_state = S_READ;
            S_ECHO_CR:  if (echo_ready) w_next_state = S_ECHO_LF;
            S_ECHO_LF:  if (echo_ready) w_next_state = S_DONE;
            S_DONE:     w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_num        <= '0;
            r_echo_byte  <= 8'h00;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
            r_echo_valid <= 1'b0;
            r_num_valid  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_busy       <= (w_next_state != S_IDLE);
            r_echo_valid <= (w_next_state == S_ECHO_DIG) || (w_next_state == S_ECHO_CR) ||
                            (w_next_state == S_ECHO_LF);
            r_num_valid  <= (w_next_state == S_DONE);

            if ((r_state == S_IDLE) && start) begin
                r_num      <= '0;
                r_overflow <= 1'b0;
                r_cnt      <= '0;
            end

            if (w_accept_digit) begin
                r_num       <= w_sat ? {WIDTH{1'b1}} : w_prod[WIDTH-1:0];
                r_overflow  <= r_overflow | w_sat;
                r_cnt       <= r_cnt + 1'b1;
                r_echo_byte <= rx_byte;
            end

            if (w_accept_cr)
                r_echo_byte <= c_CR;

            if ((r_state == S_ECHO_CR) && echo_ready)
                r_echo_byte <= c_LF;
        end
    end

    assign echo_valid = r_echo_valid;
    assign echo_byte  = r_echo_byte;
    assign busy       = r_busy;
    assign num_valid  = r_num_valid;
    assign num        = r_num;
    assign overflow   = r_overflow;

endmodule

`default_nettype wire
